fp_normalizer_pipe: RTL and testbench
=====================================

# fp_normalizer_pipe

Parametrised, two-stage pipelined normaliser for the floating-point ALU. It locates the leading one of a WIDTH-bit mantissa and computes the signed distance from that one to anchor bit REF. It then shifts the mantissa so the leading one sits at REF, collecting a sticky bit from any bits shifted out. Finally it adjusts the exponent by the distance, saturating and flagging on overflow or underflow. Valid/ready handshakes on both sides let it sit between the add/sub datapath and the rounding stage.

## Interface
Parameters:
- WIDTH, 64: mantissa width in bits; must be at least 8.
- REF, 27: anchor bit index for the normalised leading one; 0 ≤ REF < WIDTH.
- EXP_W, 11: exponent width, unsigned biased.
- DIST_W, $clog2(WIDTH)+1: width of the signed two's-complement distance.

Ports (clock and reset first):
- clk, input, 1: single clock, rising edge.
- reset_n, input, 1: asynchronous, active-low reset.
- in_valid, input, 1: input word present.
- in_ready, output, 1: block accepts the input this cycle.
- in_mant, input, WIDTH: unnormalised mantissa.
- in_exp, input, EXP_W: exponent paired with in_mant.
- out_valid, output, 1: result present.
- out_ready, input, 1: consumer takes the result this cycle.
- out_mant, output, WIDTH: normalised mantissa.
- out_exp, output, EXP_W: adjusted, saturated exponent.
- out_dist, output, DIST_W: signed distance, p − REF.
- out_sticky, output, 1: OR of all 1-bits lost in a right shift.
- out_zero, output, 1: in_mant was all zeros.
- out_ovf, output, 1: adjusted exponent exceeded 2^EXP_W − 1.
- out_unf, output, 1: adjusted exponent was below 0.

## Operation
- **Stage 1 (detect):**
  - Priority encoder finds p, the index of the highest set bit of in_mant.
  - d = p − REF, signed, DIST_W bits.
  - Zero input: zero = 1, d = 0.
  - Registers mant, exp, d, zero.
- **Stage 2 (shift/adjust):**
  - d > 0: out_mant = mant >> d; out_sticky = OR of mant[d−1:0].
  - d < 0: out_mant = mant << −d; out_sticky = 0.
  - d = 0: out_mant = mant; out_sticky = 0.
  - e = exp + d, computed in EXP_W+2-bit signed arithmetic (no wrap).
  - e > 2^EXP_W − 1: out_exp = all ones, out_ovf = 1.
  - e < 0: out_exp = 0, out_unf = 1.
  - Otherwise out_exp = e[EXP_W−1:0].
- **Zero input:** out_mant = 0, out_exp = 0, out_dist = 0, out_sticky = 0, out_ovf = 0, out_unf = 0, out_zero = 1.
- **Flags:** out_ovf and out_unf are mutually exclusive. Both are 0 whenever out_zero = 1.
- **Pipeline control:**
  - Each stage has a valid bit.
  - Stage 2 advances when out_ready is high or stage 2 is empty.
  - Stage 1 advances when stage 2 advances or stage 2 is empty.
  - in_ready = stage-1 empty OR stage 1 advancing; it is combinational from out_ready.
  - Transfers occur only on valid & ready.
  - A stalled stage holds all of its registers unchanged.
  - Results emerge in input order; no word is lost or duplicated.
- **Reset** (asynchronous, any time including mid-operation):
  - Both valid bits clear, so in-flight words are discarded.
  - out_valid = 0 and every data/flag output = 0.
  - in_ready = 1 once reset_n is high.

## Timing
- Latency: 2 cycles from accepted input to out_valid, with no stall.
- Throughput: one word per cycle while out_ready stays high.
- out_valid and out_* are registered.
- out_* stay stable while out_valid = 1 and out_ready = 0.
- Capacity: 2 words. With out_ready held low, in_ready drops after the second accepted word.
- Simultaneous accept and emit in the same cycle is legal and keeps full throughput.
- in_valid high while in_ready is low: the input is not taken, and the source must hold it.

## Test plan
All scenarios use WIDTH = 64, REF = 27, EXP_W = 11.
- **Positive distance:** in_mant = 1<<63, in_exp = 1000 → two cycles later out_mant = 1<<27, out_dist = +36, out_exp = 1036, out_sticky = 0, all flags 0.
- **Negative distance and zero distance:**
  - in_mant = 0x1, in_exp = 100 → out_mant = 1<<27, out_dist = −27, out_exp = 73.
  - in_mant = (1<<27)|1 → out_dist = 0, out_mant unchanged.
- **Sticky bit:** in_mant = (1<<40)|1, in_exp = 500 → out_dist = 13, out_mant = 1<<27, out_sticky = 1, out_exp = 513.
- **Zero and saturation:**
  - in_mant = 0 → out_zero = 1, other outputs 0.
  - in_mant = 1, in_exp = 10 → out_unf = 1, out_exp = 0.
  - in_mant = 1<<63, in_exp = 2040 → out_ovf = 1, out_exp = 2047.
- **Backpressure:**
  - Stream five words with out_ready low for cycles 2–6 → in_ready falls after two accepts.
  - Outputs hold stable during the stall.
  - After out_ready rises, all five results appear in order at one per cycle.
  - Random in_valid/out_ready patterns are checked against a reference queue model.
- **Mid-operation reset:** assert reset_n = 0 with both stages full → out_valid = 0 and outputs 0 immediately (asynchronous). After release, in_ready = 1 and the next input returns after exactly 2 cycles.

Source files
------------

// File: rtl/fp_normalizer_pipe.sv
// -----------------------------------------------------------------------------
// fp_normalizer_pipe
//
// Two-stage pipelined mantissa normaliser for the floating-point ALU.
//   Stage 1 (detect): finds the leading one p of in_mant. It then computes the
//                     signed distance d = p - REF and registers mant/exp/d/zero.
//   Stage 2 (adjust): shifts the mantissa so the leading one lands on bit REF.
//                     A right shift collects a sticky bit from the lost bits.
//                     The exponent is adjusted by d, with saturation and
//                     overflow/underflow flags.
//
// Handshake (both sides): a word transfers on a rising clk edge exactly when
// valid and ready are both high. A source holding valid while ready is low must
// keep its data unchanged. A stalled stage keeps every register it owns.
//
// Ports
//   clk, reset_n          : rising-edge clock, asynchronous active-low reset
//   in_valid / in_ready   : upstream handshake (in_ready is combinational)
//   in_mant, in_exp       : unnormalised mantissa and its biased exponent
//   out_valid / out_ready : downstream handshake (out_valid registered)
//   out_mant              : normalised mantissa
//   out_exp               : adjusted, saturated exponent
//   out_dist              : signed distance p - REF (two's complement)
//   out_sticky            : OR of 1-bits shifted out on a right shift
//   out_zero              : in_mant was all zeros
//   out_ovf, out_unf      : exponent saturated high / low
// -----------------------------------------------------------------------------
module fp_normalizer_pipe #(
   parameter int WIDTH  = 64,
   parameter int REF    = 27,
   parameter int EXP_W  = 11,
   parameter int DIST_W = $clog2(WIDTH) + 1
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [WIDTH-1:0]  in_mant,
   input  logic [EXP_W-1:0]  in_exp,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [WIDTH-1:0]  out_mant,
   output logic [EXP_W-1:0]  out_exp,
   output logic [DIST_W-1:0] out_dist,
   output logic              out_sticky,
   output logic              out_zero,
   output logic              out_ovf,
   output logic              out_unf
);

   localparam int EW = EXP_W + 2;  // wide enough for exp + d without wrap

   // ---------------------------------------------------------------------------
   // Pipeline control
   // ---------------------------------------------------------------------------
   logic s1_valid_q, s1_valid_d;
   logic s2_valid_q, s2_valid_d;
   logic s2_adv;
   logic s1_load;
   logic s2_load;

   // Stage 2 moves when its word is taken or when it holds nothing. Stage 1
   // moves with stage 2, so the front end accepts whenever stage 1 empties.
   assign s2_adv   = out_ready | ~s2_valid_q;
   assign in_ready = ~s1_valid_q | s2_adv;
   assign s1_load  = in_valid & in_ready;
   assign s2_load  = s2_adv & s1_valid_q;

   always_comb begin
      s1_valid_d = s1_valid_q;
      s2_valid_d = s2_valid_q;
      if (in_ready) s1_valid_d = in_valid;
      if (s2_adv)   s2_valid_d = s1_valid_q;
   end

   // ---------------------------------------------------------------------------
   // Stage 1: leading-one detection
   // ---------------------------------------------------------------------------
   logic [DIST_W-2:0] lead_idx;
   logic              zero_d;
   logic [DIST_W-1:0] dist_d;

   // Scanning upward lets the highest set bit win the last assignment.
   always_comb begin
      lead_idx = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if (in_mant[i]) lead_idx = (DIST_W-1)'(i);
      end
   end

   assign zero_d = ~|in_mant;
   // Modular subtraction gives the two's-complement bit pattern of p - REF.
   assign dist_d = zero_d ? '0 : ({1'b0, lead_idx} - DIST_W'(REF));

   logic [WIDTH-1:0]  s1_mant_q;
   logic [EXP_W-1:0]  s1_exp_q;
   logic [DIST_W-1:0] s1_dist_q;
   logic              s1_zero_q;

   // ---------------------------------------------------------------------------
   // Stage 2: shift, sticky and exponent adjust (combinational from stage 1)
   // ---------------------------------------------------------------------------
   logic              dist_neg;
   logic              dist_pos;
   logic [DIST_W-1:0] neg_amt;
   logic [WIDTH-1:0]  lost_mask;
   logic [EW-1:0]     dist_ext;
   logic [EW-1:0]     exp_sum;
   logic [WIDTH-1:0]  mant_d;
   logic [EXP_W-1:0]  exp_d;
   logic              sticky_d;
   logic              ovf_d;
   logic              unf_d;

   assign dist_neg  = s1_dist_q[DIST_W-1];
   assign dist_pos  = ~dist_neg & (|s1_dist_q);
   assign neg_amt   = '0 - s1_dist_q;
   // Bits [d-1:0] are the ones that fall off the bottom on a right shift by d.
   assign lost_mask = ~({WIDTH{1'b1}} << s1_dist_q);
   assign dist_ext  = {{(EW-DIST_W){s1_dist_q[DIST_W-1]}}, s1_dist_q};
   assign exp_sum   = {2'b00, s1_exp_q} + dist_ext;

   always_comb begin
      mant_d   = s1_mant_q;
      sticky_d = 1'b0;
      exp_d    = exp_sum[EXP_W-1:0];
      ovf_d    = 1'b0;
      unf_d    = 1'b0;
      if (dist_pos) begin
         mant_d   = s1_mant_q >> s1_dist_q;
         sticky_d = |(s1_mant_q & lost_mask);
      end else if (dist_neg) begin
         mant_d = s1_mant_q << neg_amt;
      end
      // Top bit set means negative; next bit set (when non-negative) means
      // the sum passed the largest representable exponent.
      if (exp_sum[EW-1]) begin
         exp_d = '0;
         unf_d = 1'b1;
      end else if (exp_sum[EXP_W]) begin
         exp_d = '1;
         ovf_d = 1'b1;
      end
      if (s1_zero_q) begin
         mant_d   = '0;
         sticky_d = 1'b0;
         exp_d    = '0;
         ovf_d    = 1'b0;
         unf_d    = 1'b0;
      end
   end

   // ---------------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------------
   logic [WIDTH-1:0]  out_mant_q;
   logic [EXP_W-1:0]  out_exp_q;
   logic [DIST_W-1:0] out_dist_q;
   logic              out_sticky_q;
   logic              out_zero_q;
   logic              out_ovf_q;
   logic              out_unf_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1_valid_q   <= 1'b0;
         s2_valid_q   <= 1'b0;
         s1_mant_q    <= '0;
         s1_exp_q     <= '0;
         s1_dist_q    <= '0;
         s1_zero_q    <= 1'b0;
         out_mant_q   <= '0;
         out_exp_q    <= '0;
         out_dist_q   <= '0;
         out_sticky_q <= 1'b0;
         out_zero_q   <= 1'b0;
         out_ovf_q    <= 1'b0;
         out_unf_q    <= 1'b0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s2_valid_q <= s2_valid_d;
         if (s1_load) begin
            s1_mant_q <= in_mant;
            s1_exp_q  <= in_exp;
            s1_dist_q <= dist_d;
            s1_zero_q <= zero_d;
         end
         if (s2_load) begin
            out_mant_q   <= mant_d;
            out_exp_q    <= exp_d;
            out_dist_q   <= s1_dist_q;
            out_sticky_q <= sticky_d;
            out_zero_q   <= s1_zero_q;
            out_ovf_q    <= ovf_d;
            out_unf_q    <= unf_d;
         end
      end
   end

   assign out_valid  = s2_valid_q;
   assign out_mant   = out_mant_q;
   assign out_exp    = out_exp_q;
   assign out_dist   = out_dist_q;
   assign out_sticky = out_sticky_q;
   assign out_zero   = out_zero_q;
   assign out_ovf    = out_ovf_q;
   assign out_unf    = out_unf_q;

endmodule

// File: tb/tb_fp_normalizer_pipe.sv
// -----------------------------------------------------------------------------
// tb_fp_normalizer_pipe
//
// Drives fp_normalizer_pipe with its default parameters (64/27/11). Results
// are compared against a reference function: it finds the top set bit by
// plain search and does integer exponent arithmetic with clamping. Streams
// are checked through an expected-result queue.
// -----------------------------------------------------------------------------
module tb_fp_normalizer_pipe;

   localparam int W  = 64;
   localparam int EW = 11;
   localparam int DW = 7;
   localparam int RW = W + EW + DW + 4;  // packed result width

   // ---------------------------------------------------------------------------
   // Clock / reset / DUT
   // ---------------------------------------------------------------------------
   logic          clk = 1'b0;
   logic          reset_n;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  in_mant;
   logic [EW-1:0] in_exp;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  out_mant;
   logic [EW-1:0] out_exp;
   logic [DW-1:0] out_dist;
   logic          out_sticky;
   logic          out_zero;
   logic          out_ovf;
   logic          out_unf;

   always #5 clk = ~clk;

   fp_normalizer_pipe dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_mant    (in_mant),
      .in_exp     (in_exp),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_mant   (out_mant),
      .out_exp    (out_exp),
      .out_dist   (out_dist),
      .out_sticky (out_sticky),
      .out_zero   (out_zero),
      .out_ovf    (out_ovf),
      .out_unf    (out_unf)
   );

   int n_checks = 0;
   int n_pass   = 0;
   logic [RW-1:0] exp_q[$];

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
      $fatal(1, "watchdog");
   end

   // ---------------------------------------------------------------------------
   // Reference model: {mant, exp, dist, sticky, zero, ovf, unf}
   // ---------------------------------------------------------------------------
   function automatic logic [RW-1:0] model(input logic [W-1:0] m, input logic [EW-1:0] e);
      int p, d, ex;
      logic [W-1:0] om;
      logic st, ov, un;
      if (m == '0) return {{W{1'b0}}, {EW{1'b0}}, {DW{1'b0}}, 1'b0, 1'b1, 1'b0, 1'b0};
      p = W - 1;
      while (m[p] == 1'b0) p--;
      d = p - 27;
      st = 1'b0;
      if (d > 0) begin
         om = m >> d;
         st = ((m & ((64'd1 << d) - 64'd1)) != 64'd0);
      end else begin
         om = m << (-d);
      end
      ex = int'(e) + d;
      ov = 1'b0;
      un = 1'b0;
      if (ex > 2047) begin
         ex = 2047;
         ov = 1'b1;
      end else if (ex < 0) begin
         ex = 0;
         un = 1'b1;
      end
      return {om, EW'(ex), DW'(d), st, 1'b0, ov, un};
   endfunction

   function automatic logic [RW-1:0] got_vec();
      return {out_mant, out_exp, out_dist, out_sticky, out_zero, out_ovf, out_unf};
   endfunction

   function automatic logic [W-1:0] rand_mant();
      logic [W-1:0] r;
      r = {$urandom(), $urandom()};
      if ($urandom_range(0, 9) == 0) return '0;
      return r >> $urandom_range(0, 63);
   endfunction

   // ---------------------------------------------------------------------------
   // Driver: samples the handshakes at the current time (mid-cycle), updates
   // the expected queue, then advances to 1 time unit after the next edge.
   // ---------------------------------------------------------------------------
   task automatic sb_step(output bit acc, output bit emit,
                          output logic [RW-1:0] got, output logic [RW-1:0] want);
      acc  = in_valid && in_ready;
      emit = out_valid && out_ready;
      got  = '0;
      want = '0;
      if (emit) begin
         got = got_vec();
         if (exp_q.size() > 0) want = exp_q.pop_front();
         else want = ~got;
      end
      if (acc) exp_q.push_back(model(in_mant, in_exp));
      @(posedge clk);
      #1;
   endtask

   // ---------------------------------------------------------------------------
   // Scenarios
   // ---------------------------------------------------------------------------
   task automatic test_reset();
      #2;
      n_checks++;
      if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b required 0", out_valid);
      else n_pass++;
      n_checks++;
      if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b required 1", in_ready);
      else n_pass++;
      n_checks++;
      if (got_vec() !== '0) $display("FAIL reset_outputs: got %h required 0", got_vec());
      else n_pass++;
   endtask

   // Single word into an empty pipe with out_ready high; checks 2-cycle latency.
   task automatic run_one(input string name, input logic [W-1:0] m, input int e,
                          input logic [W-1:0] em, input int eexp, input int edist,
                          input logic es, input logic ez, input logic eo, input logic eu);
      logic [RW-1:0] want;
      want = {em, EW'(eexp), DW'(edist), es, ez, eo, eu};
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_mant   = m;
      in_exp    = EW'(e);
      #2;
      n_checks++;
      if (in_ready !== 1'b1) $display("FAIL %s_in_ready: got %b required 1", name, in_ready);
      else n_pass++;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      #2;
      n_checks++;
      if (out_valid !== 1'b0) $display("FAIL %s_early_valid: got %b required 0", name, out_valid);
      else n_pass++;
      @(posedge clk);
      #3;
      n_checks++;
      if (out_valid !== 1'b1) $display("FAIL %s_valid: got %b required 1", name, out_valid);
      else n_pass++;
      n_checks++;
      if (got_vec() !== want) $display("FAIL %s_result: got %h required %h", name, got_vec(), want);
      else n_pass++;
      @(posedge clk);
   endtask

   task automatic test_positive_distance();
      run_one("pos_dist", 64'd1 << 63, 1000, 64'd1 << 27, 1036, 36, 0, 0, 0, 0);
   endtask

   task automatic test_negative_and_zero_distance();
      run_one("neg_dist", 64'd1, 100, 64'd1 << 27, 73, -27, 0, 0, 0, 0);
      run_one("zero_dist", (64'd1 << 27) | 64'd1, 300, (64'd1 << 27) | 64'd1, 300, 0, 0, 0, 0, 0);
   endtask

   task automatic test_sticky();
      run_one("sticky", (64'd1 << 40) | 64'd1, 500, 64'd1 << 27, 513, 13, 1, 0, 0, 0);
   endtask

   task automatic test_zero_and_saturation();
      run_one("zero_in", 64'd0, 777, 64'd0, 0, 0, 0, 1, 0, 0);
      run_one("underflow", 64'd1, 10, 64'd1 << 27, 0, -27, 0, 0, 0, 1);
      run_one("overflow", 64'd1 << 63, 2040, 64'd1 << 27, 2047, 36, 0, 0, 1, 0);
   endtask

   task automatic test_backpressure();
      logic [W-1:0]  w[5];
      logic [EW-1:0] x[5];
      logic [RW-1:0] first, got, want;
      bit acc, emit;
      int idx, emits;
      for (int i = 0; i < 5; i++) begin
         w[i] = rand_mant();
         x[i] = EW'($urandom_range(0, 2047));
      end
      exp_q.delete();
      idx   = 0;
      first = '0;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      for (int cyc = 0; cyc < 6; cyc++) begin
         in_valid = (idx < 5);
         in_mant  = w[idx < 5 ? idx : 4];
         in_exp   = x[idx < 5 ? idx : 4];
         #2;
         if (cyc == 2) first = got_vec();
         if (cyc >= 2) begin
            n_checks++;
            if (in_ready !== 1'b0) $display("FAIL bp_in_ready_cyc%0d: got %b required 0", cyc, in_ready);
            else n_pass++;
         end
         if (cyc == 5) begin
            n_checks++;
            if (out_valid !== 1'b1) $display("FAIL bp_stall_valid: got %b required 1", out_valid);
            else n_pass++;
            n_checks++;
            if (got_vec() !== first) $display("FAIL bp_stall_stable: got %h required %h", got_vec(), first);
            else n_pass++;
            n_checks++;
            if (first !== model(w[0], x[0])) $display("FAIL bp_first_word: got %h required %h", first, model(w[0], x[0]));
            else n_pass++;
         end
         sb_step(acc, emit, got, want);
         if (acc) idx++;
      end
      n_checks++;
      if (idx !== 2) $display("FAIL bp_accept_count: got %0d required 2", idx);
      else n_pass++;
      out_ready = 1'b1;
      emits = 0;
      for (int cyc = 0; cyc < 5; cyc++) begin
         in_valid = (idx < 5);
         in_mant  = w[idx < 5 ? idx : 4];
         in_exp   = x[idx < 5 ? idx : 4];
         #2;
         n_checks++;
         if (out_valid !== 1'b1) $display("FAIL bp_drain_valid_cyc%0d: got %b required 1", cyc, out_valid);
         else n_pass++;
         sb_step(acc, emit, got, want);
         if (acc) idx++;
         if (emit) begin
            emits++;
            n_checks++;
            if (got !== want) $display("FAIL bp_drain_order_%0d: got %h required %h", cyc, got, want);
            else n_pass++;
         end
      end
      in_valid = 1'b0;
      n_checks++;
      if (emits !== 5 || exp_q.size() !== 0)
         $display("FAIL bp_drain_count: got %0d emits/%0d left required 5/0", emits, exp_q.size());
      else n_pass++;
   endtask

   task automatic test_random_stream();
      logic [RW-1:0] got, want;
      bit acc, emit;
      int bad;
      exp_q.delete();
      bad = 0;
      in_valid = 1'b0;
      for (int cyc = 0; cyc < 400; cyc++) begin
         if (!in_valid || acc) begin
            in_valid = ($urandom_range(0, 99) < 70);
            in_mant  = rand_mant();
            in_exp   = EW'($urandom_range(0, 2047));
         end
         out_ready = ($urandom_range(0, 99) < 60);
         #2;
         sb_step(acc, emit, got, want);
         if (emit) begin
            n_checks++;
            if (got !== want) begin
               $display("FAIL rand_result_cyc%0d: got %h required %h", cyc, got, want);
               bad++;
            end else n_pass++;
         end
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int cyc = 0; cyc < 10 && exp_q.size() > 0; cyc++) begin
         #2;
         sb_step(acc, emit, got, want);
         if (emit) begin
            n_checks++;
            if (got !== want) $display("FAIL rand_drain: got %h required %h", got, want);
            else n_pass++;
         end
      end
      n_checks++;
      if (exp_q.size() !== 0) $display("FAIL rand_leftover: got %0d words pending required 0", exp_q.size());
      else n_pass++;
   endtask

   task automatic test_mid_reset();
      logic [W-1:0]  m;
      logic [EW-1:0] e;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_mant   = 64'hFFFF_0000_1234_5678;
      in_exp    = 11'd900;
      @(posedge clk);
      #1;
      in_mant   = 64'h0000_0000_0000_00F0;
      @(posedge clk);
      #1;
      in_valid  = 1'b0;
      #2;
      n_checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0)
         $display("FAIL mrst_full: got valid=%b ready=%b required 1/0", out_valid, in_ready);
      else n_pass++;
      reset_n = 1'b0;
      #1;
      n_checks++;
      if (out_valid !== 1'b0) $display("FAIL mrst_out_valid: got %b required 0", out_valid);
      else n_pass++;
      n_checks++;
      if (got_vec() !== '0) $display("FAIL mrst_outputs: got %h required 0", got_vec());
      else n_pass++;
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      exp_q.delete();
      #2;
      n_checks++;
      if (in_ready !== 1'b1) $display("FAIL mrst_in_ready: got %b required 1", in_ready);
      else n_pass++;
      m = rand_mant() | 64'd1;
      e = EW'($urandom_range(0, 2047));
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_mant   = m;
      in_exp    = e;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      #2;
      n_checks++;
      if (out_valid !== 1'b0) $display("FAIL mrst_early_valid: got %b required 0", out_valid);
      else n_pass++;
      @(posedge clk);
      #3;
      n_checks++;
      if (out_valid !== 1'b1 || got_vec() !== model(m, e))
         $display("FAIL mrst_latency: got valid=%b %h required 1 %h", out_valid, got_vec(), model(m, e));
      else n_pass++;
   endtask

   // ---------------------------------------------------------------------------
   // Sequence and report
   // ---------------------------------------------------------------------------
   initial begin
      reset_n   = 1'b0;
      in_valid  = 1'b0;
      in_mant   = '0;
      in_exp    = '0;
      out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b1;
      test_reset();
      test_positive_distance();
      test_negative_and_zero_distance();
      test_sticky();
      test_zero_and_saturation();
      test_backpressure();
      test_random_stream();
      test_mid_reset();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
